ram_stream_writer: RTL and testbench

RAM_STREAM_WRITER -- requirements
Module: ram_stream_writer

---
 rtl/ram_stream_writer_pkg.sv | 17 +
 rtl/ram_stream_writer_ack_watchdog.sv | 37 +++
 rtl/ram_stream_writer.sv | 170 +++++++++++++++++
 tb/tb_ram_stream_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_writer_pkg.sv
// ram_stream_writer_pkg
//   Shared definitions for the RAM stream writer: FSM state encoding and the
//   default geometry (word width, RAM depth, words per sphere record).
package ram_stream_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCEPT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_RAM_DEPTH    = 32;
    localparam int DEF_RECORD_WORDS = 8;

endpackage

// File: rtl/ram_stream_writer_ack_watchdog.sv
// ack_watchdog
//   Down-counter guarding the RAM write acknowledge. Reloaded when a word is
//   accepted (the cycle before WAIT_ACK is entered) and counted down while
//   the writer sits in WAIT_ACK; expired is raised in the ACK_TIMEOUT-th
//   WAIT_ACK cycle.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   arm        : reload the counter (word accepted)
//   active     : writer is in WAIT_ACK
//   expired    : terminal count reached while active
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (arm) begin
            cnt_q <= CW'(ACK_TIMEOUT - 1);
        end else if (active && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = active && (cnt_q == '0);

endmodule

// File: rtl/ram_stream_writer.sv
// ram_stream_writer
//   Accepts a valid/ready word stream and writes it into a RAM starting at
//   address 0, one word per three cycles (accept, write, acknowledge).
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse in IDLE begins a load at address 0
//   in_data/valid/last, in_ready : input stream handshake
//   ram_addressin, ram_datain, ram_cs, ram_we : RAM write port
//   ram_write_done    : registered write acknowledge from the RAM
//   ram_fm            : RAM full flag
//   busy, load_done   : load in progress / one-cycle end-of-load pulse
//   word_count, record_count, partial : progress of current/last load
//   overflow, ack_error : sticky error flags, cleared by start
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for start; results of the last load held
// ST_ACCEPT   | in_ready high until a word is taken or RAM is full
// ST_WAIT_ACK | write pulse issued, waiting for ram_write_done
// ST_DONE     | one-cycle load_done pulse
module ram_stream_writer
    import ram_stream_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 32,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int RECORD_WORDS = DEF_RECORD_WORDS,
    parameter int ACK_TIMEOUT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_addressin,
    output logic [DATA_WIDTH-1:0] ram_datain,
    output logic                  ram_cs,
    output logic                  ram_we,
    input  logic                  ram_write_done,
    input  logic                  ram_fm,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic [ADDR_WIDTH-1:0] record_count,
    output logic                  partial,
    output logic                  overflow,
    output logic                  ack_error
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_M1 = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] REC_MASK = ADDR_WIDTH'(RECORD_WORDS - 1);
    localparam int                    REC_SHIFT = $clog2(RECORD_WORDS);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_count_q;
    logic                  last_q;
    logic                  ram_we_q;
    logic                  overflow_q;
    logic                  ack_error_q;

    logic addr_at_depth;
    logic fm_block;
    logic ready_int;
    logic accept_fire;
    logic ovf_event;
    logic ack_ok;
    logic ack_expired;

    // The write address always equals the number of acknowledged words.
    assign addr_at_depth = (word_count_q == DEPTH_A);
    assign fm_block      = ram_fm && (word_count_q >= DEPTH_M1);
    assign ready_int     = (state_q == ST_ACCEPT) && !addr_at_depth && !fm_block;
    assign accept_fire   = ready_int && in_valid;
    // A full RAM is detected back in ACCEPT so that it raises overflow through
    // the same rule as any other refused word.
    assign ovf_event     = (state_q == ST_ACCEPT) &&
                           (addr_at_depth || (fm_block && in_valid));
    assign ack_ok        = (state_q == ST_WAIT_ACK) && ram_write_done;

    ack_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .arm    (accept_fire),
        .active (state_q == ST_WAIT_ACK),
        .expired(ack_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (ovf_event)        state_d = ST_DONE;
                else if (accept_fire) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ack_ok)           state_d = last_q ? ST_DONE : ST_ACCEPT;
                else if (ack_expired) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ready_int;
        ram_cs    = (state_q == ST_WAIT_ACK);
        ram_we    = ram_we_q;
        busy      = (state_q == ST_ACCEPT) || (state_q == ST_WAIT_ACK);
        load_done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_q  <= '0;
            last_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addressin <= '0;
            ram_datain    <= '0;
            overflow_q    <= 1'b0;
            ack_error_q   <= 1'b0;
        end else begin
            // Single-cycle write strobe: the FSM leaves ACCEPT on the same
            // edge, so accept_fire can never be high two cycles running.
            ram_we_q <= accept_fire;
            if ((state_q == ST_IDLE) && start) begin
                word_count_q <= '0;
                overflow_q   <= 1'b0;
                ack_error_q  <= 1'b0;
            end
            if (accept_fire) begin
                ram_addressin <= word_count_q;
                ram_datain    <= in_data;
                last_q        <= in_last;
            end
            if (ack_ok) begin
                word_count_q <= word_count_q + 1'b1;
            end else if (ack_expired) begin
                ack_error_q <= 1'b1;
            end
            if (ovf_event) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign word_count   = word_count_q;
    assign record_count = word_count_q >> REC_SHIFT;
    assign partial      = |(word_count_q & REC_MASK);
    assign overflow     = overflow_q;
    assign ack_error    = ack_error_q;

endmodule

// File: tb/tb_ram_stream_writer.sv
// tb_ram_stream_writer
//   Drives word streams into ram_stream_writer against a RAM model with a
//   1-cycle registered write_done, and compares results with expectations
//   computed from the load rules (words written, flags, 3-cycle throughput).
module tb_ram_stream_writer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;
    localparam int RECW  = 8;
    localparam int TMO   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ram_addressin;
    logic [DW-1:0] ram_datain;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_write_done = 1'b0;
    logic          ram_fm;
    logic          busy;
    logic          load_done;
    logic [AW-1:0] word_count;
    logic [AW-1:0] record_count;
    logic          partial;
    logic          overflow;
    logic          ack_error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // RAM model state
    logic [DW-1:0] mem [DEPTH];
    int            wr_cnt = 0;
    int            withhold_idx = -1;
    logic          ram_clear = 1'b0;

    // monitor state
    logic mon_clear = 1'b0;
    int   ld_pulses = 0;
    int   we_viol   = 0;
    logic prev_we   = 1'b0;

    ram_stream_writer #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .RAM_DEPTH   (DEPTH),
        .RECORD_WORDS(RECW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .ram_addressin (ram_addressin),
        .ram_datain    (ram_datain),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_write_done(ram_write_done),
        .ram_fm        (ram_fm),
        .busy          (busy),
        .load_done     (load_done),
        .word_count    (word_count),
        .record_count  (record_count),
        .partial       (partial),
        .overflow      (overflow),
        .ack_error     (ack_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_clear) begin
            wr_cnt         <= 0;
            ram_write_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ram_cs && ram_we) begin
            if (ram_addressin < AW'(DEPTH)) mem[ram_addressin[4:0]] <= ram_datain;
            wr_cnt         <= wr_cnt + 1;
            ram_write_done <= (wr_cnt != withhold_idx);
        end else begin
            ram_write_done <= 1'b0;
        end
    end

    assign ram_fm = (wr_cnt >= DEPTH);

    always @(negedge clk) begin
        if (mon_clear) begin
            ld_pulses = 0;
            we_viol   = 0;
            prev_we   = 1'b0;
        end else begin
            if (load_done) ld_pulses++;
            if (ram_we && prev_we) we_viol++;
            prev_we = ram_we;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_env();
        @(negedge clk);
        ram_clear = 1'b1;
        mon_clear = 1'b1;
        @(negedge clk);
        ram_clear = 1'b0;
        mon_clear = 1'b0;
    endtask

    // len words, last on word len-1; base<0 gives random data.
    // withhold: index of write whose ack the RAM withholds (-1 none).
    // busy_at: re-pulse start once this many words are accepted (-1 none).
    task automatic run_load(input string nm, input int len, input int gap_pct,
                            input int withhold, input int busy_at,
                            input bit timed, input int base);
        logic [DW-1:0] words [$];
        int  idx, start_cyc, ld_cyc, capped, acc_exp, wc_exp, lat_exp;
        bit  cur_valid, hs, done_seen, bp;
        for (int i = 0; i < len; i++)
            words.push_back((base >= 0) ? DW'(base + i) : DW'($urandom));
        withhold_idx = withhold;
        clear_env();
        idx = 0; cur_valid = 0; done_seen = 0; bp = 0; ld_cyc = 0;
        start = 1'b1;
        start_cyc = cyc + 1;
        for (int c = 0; c < 1500 && !done_seen; c++) begin
            if (c > 0) begin
                start = 1'b0;
                if (busy_at > 0 && idx == busy_at && !bp) begin
                    start = 1'b1;
                    bp = 1;
                end
            end
            if (idx < len) begin
                if (!cur_valid) cur_valid = ($urandom_range(99) >= gap_pct);
                in_valid = cur_valid;
                in_data  = words[idx];
                in_last  = (idx == len - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            hs = in_valid && in_ready;
            if (load_done) begin
                done_seen = 1;
                ld_cyc = cyc;
            end
            @(posedge clk);
            if (hs) begin
                idx++;
                cur_valid = 0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);

        capped  = (len < DEPTH) ? len : DEPTH;
        if (withhold >= 0) begin
            wc_exp  = withhold;
            acc_exp = withhold + 1;
            lat_exp = 3 * withhold + 1 + TMO;
        end else begin
            wc_exp  = capped;
            acc_exp = capped;
            lat_exp = (len > DEPTH) ? 3 * DEPTH + 1 : 3 * len;
        end
        chk({nm, "_done_seen"}, done_seen, 1);
        chk({nm, "_word_count"}, word_count, wc_exp);
        chk({nm, "_record_count"}, record_count, wc_exp / RECW);
        chk({nm, "_partial"}, partial, (wc_exp % RECW) != 0);
        chk({nm, "_overflow"}, overflow, (withhold < 0) && (len > DEPTH));
        chk({nm, "_ack_error"}, ack_error, withhold >= 0);
        chk({nm, "_accepted"}, idx, acc_exp);
        chk({nm, "_ld_pulses"}, ld_pulses, 1);
        chk({nm, "_we_consec"}, we_viol, 0);
        chk({nm, "_busy_after"}, {busy, in_ready}, 2'b00);
        if (timed) chk({nm, "_latency"}, ld_cyc - start_cyc, lat_exp);
        for (int i = 0; i < acc_exp && i < DEPTH; i++)
            chk($sformatf("%s_mem%0d", nm, i), mem[i], words[i]);
        if (acc_exp < DEPTH)
            chk($sformatf("%s_mem%0d_untouched", nm, acc_exp), mem[acc_exp], 0);
    endtask

    task automatic reset_in_wait_ack();
        int  idx;
        bit  hs;
        withhold_idx = -1;
        clear_env();
        idx = 0;
        start = 1'b1;
        for (int c = 0; c < 50 && idx < 2; c++) begin
            if (c > 0) start = 1'b0;
            in_valid = 1'b1;
            in_data  = DW'(32'hA0 + idx);
            in_last  = 1'b0;
            #1;
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) idx++;
            if (idx < 2) @(negedge clk);
        end
        start = 1'b0;
        #1;
        chk("rst_reached_2nd", idx, 2);
        chk("rst_pre_wait", {busy, ram_cs, ram_we}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("rst_outs_zero", |{in_ready, ram_addressin, ram_datain, ram_cs, ram_we,
                               busy, load_done, word_count, record_count, partial,
                               overflow, ack_error}, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_load_done", ld_pulses, 0);
        chk("rst_idle_after", {busy, in_ready, word_count[0]}, 3'b000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len, gap, wh, cap;
        repeat (3) @(negedge clk);
        chk("reset_outs", |{in_ready, ram_addressin, ram_datain, ram_cs, ram_we,
                            busy, load_done, word_count, record_count, partial,
                            overflow, ack_error}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_load("seq16", 16, 0, -1, -1, 1, 32'h10);
        run_load("w5", 5, 0, -1, -1, 1, -1);
        run_load("ovf40", 40, 0, -1, -1, 1, -1);
        run_load("nak3", 10, 0, 2, -1, 1, -1);
        reset_in_wait_ack();
        run_load("busystart", 10, 0, -1, 4, 1, -1);
        run_load("one", 1, 0, -1, -1, 1, -1);
        run_load("full32", 32, 0, -1, -1, 1, -1);

        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(36, 1);
            gap = $urandom_range(60, 0);
            cap = (len < DEPTH) ? len : DEPTH;
            wh  = ($urandom_range(4) == 0) ? $urandom_range(cap - 1, 0) : -1;
            run_load($sformatf("rnd%0d", t), len, gap, wh, -1, gap == 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
